q2_capture: RTL

Sequencer and capture engine for the lab's selectable-output flip-flop circuit (the X/Y/Z/S0/S1 → T datapath).
- Drives the stimulus and select lines, then sweeps all four select codes.
- For each code, samples the serial T output for DEPTH cycles and packs the samples into a result word.
- Hands each word out over a valid/ready handshake.
- Sits between the circuit under test and the board's display and readout logic.

---
 rtl/q2_capture_if.sv | 26 ++
 rtl/q2_capture.sv | 122 ++++++++++++
 2 files changed

// File: rtl/q2_capture_if.sv
// rtl/q2_capture_if.sv - result stream bundle between q2_capture and its consumer
interface q2_capture_if #(
    parameter int DEPTH = 8
) ();
    logic [DEPTH-1:0] res_data;
    logic [1:0]       res_sel;
    logic             res_par;
    logic             res_valid;
    logic             res_ready;

    modport master (
        output res_data,
        output res_sel,
        output res_par,
        output res_valid,
        input  res_ready
    );

    modport slave (
        input  res_data,
        input  res_sel,
        input  res_par,
        input  res_valid,
        output res_ready
    );
endinterface

// File: rtl/q2_capture.sv
// rtl/q2_capture.sv - select sweep sequencer and T capture engine; CAPTURE_PARITY_EN adds res_par
module q2_capture #(
    parameter int DEPTH  = 8,
    parameter int SETTLE = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    input  logic          T,
    output logic          X,
    output logic          Y,
    output logic          Z,
    output logic          S0,
    output logic          S1,
    output logic          done,
    q2_capture_if.master  res
);
    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_RESULT} state_t;

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);
    localparam logic [7:0] SAMPLE_LAST = 8'(DEPTH - 1);

    state_t           state, state_next;
    logic [7:0]       cnt;
    logic [1:0]       sel;
    logic [2:0]       stim;
    logic [DEPTH-1:0] shreg;
    logic [DEPTH-1:0] shreg_next;
    logic [DEPTH:0]   shreg_ext;
    logic             settle_last, sample_last, xfer;

    always_comb begin
        shreg_ext   = {shreg, T};
        shreg_next  = shreg_ext[DEPTH-1:0];
        settle_last = (cnt == SETTLE_LAST);
        sample_last = (cnt == SAMPLE_LAST);
        xfer        = res.res_valid && res.res_ready;
        state_next  = state;
        case (state)
            S_IDLE:   if (start) state_next = S_SETTLE;
            S_SETTLE: if (settle_last) state_next = S_SAMPLE;
            S_SAMPLE: if (sample_last) state_next = S_RESULT;
            S_RESULT: if (xfer) state_next = (sel == 2'd3) ? S_IDLE : S_SETTLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt           <= '0;
            sel           <= '0;
            stim          <= '0;
            shreg         <= '0;
            done          <= 1'b0;
            res.res_data  <= '0;
            res.res_sel   <= '0;
            res.res_valid <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        sel  <= '0;
                        stim <= '0;
                        cnt  <= '0;
                    end
                end
                S_SETTLE: begin
                    cnt <= settle_last ? 8'd0 : cnt + 8'd1;
                end
                S_SAMPLE: begin
                    shreg <= shreg_next;
                    stim  <= stim + 3'd1;
                    if (sample_last) begin
                        cnt           <= '0;
                        res.res_data  <= shreg_next;
                        res.res_sel   <= sel;
                        res.res_valid <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                S_RESULT: begin
                    if (xfer) begin
                        res.res_valid <= 1'b0;
                        // The last select leaves sel/stim as they were so the display keeps them
                        if (sel != 2'd3) begin
                            sel  <= sel + 2'd1;
                            stim <= '0;
                            cnt  <= '0;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef CAPTURE_PARITY_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            res.res_par <= 1'b0;
        else if (state == S_SAMPLE && sample_last)
            res.res_par <= ^shreg_next;
    end
`else
    assign res.res_par = 1'b0;
`endif

    assign busy      = (state != S_IDLE);
    assign {X, Y, Z} = stim;
    assign S0        = sel[1];
    assign S1        = sel[0];
endmodule
